// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit producing HI/LO with a busy stall flag
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;
   logic        state;
   logic [31:0] cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [63:0] prod_s, prod_u;
   logic [31:0] b_nz, abs_a, abs_b, uq, ur, mq, mr, res_hi, res_lo;
   logic        sgn, wr;
   assign busy   = state;
   assign sgn    = op_q == 3'd3;
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'b0, a_q} * {32'b0, b_q};
   // one unsigned divider serves div and divu; signs are reapplied afterwards
   assign b_nz   = (b_q == 32'b0) ? 32'd1 : b_q;
   assign abs_a  = (sgn && a_q[31]) ? -a_q : a_q;
   assign abs_b  = (sgn && b_nz[31]) ? -b_nz : b_nz;
   assign uq     = abs_a / abs_b;
   assign ur     = abs_a % abs_b;
   assign mq     = (sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
   assign mr     = (sgn && a_q[31]) ? -ur : ur;
   always_comb begin
      res_hi = (op_q == 3'd1) ? prod_s[63:32] : (op_q == 3'd2) ? prod_u[63:32] : mr;
      res_lo = (op_q == 3'd1) ? prod_s[31:0]  : (op_q == 3'd2) ? prod_u[31:0]  : mq;
      wr     = (op_q == 3'd1) || (op_q == 3'd2) || (b_q != 32'b0);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else if (state == RUN) begin
         cnt <= cnt - 32'd1;
         if (cnt == 32'd1) begin
            state <= IDLE;
            if (wr) begin
               HI <= res_hi;
               LO <= res_lo;
            end
         end
      end else if (start && MDUOp >= 3'd1 && MDUOp <= 3'd4) begin
         state <= RUN;
         op_q  <= MDUOp;
         a_q   <= A;
         b_q   <= B;
         cnt   <= (MDUOp <= 3'd2) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
      end else if (MDUOp == 3'd5) begin
         HI <= A;
      end else if (MDUOp == 3'd6) begin
         LO <= A;
      end
   end
endmodule

// File: doc/mdu.md
Name: mdu

Overview:
Multiply/divide unit that sits beside the ALU in the execute path. It takes the same rs/rt operand pair that feeds the ALU and produces the HI/LO results read back through the register write-back mux (mfhi/mflo). It is multi-cycle and exposes a busy flag so the controller can stall dependent MDU instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  launch the op on MDUOp; meaningful only for MDUOp 1..4
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op)
A  input  32  operand from rs (Grs)
B  input  32  operand from rt (Grt)
busy  output  1  computation in progress
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset, sampled at the clock edge: HI=0, LO=0, busy=0, counter=0, latched op/operands cleared. Reset overrides everything, including an in-flight op, which is discarded with no HI/LO update.
- States: IDLE (busy=0) and RUN (busy=1), with a down-counter.
- IDLE, start=1, MDUOp in 1..4 at edge T0:
  - latch A, B, op;
  - counter = MULT_CYCLES or DIV_CYCLES;
  - enter RUN. busy is high in cycles T0+1 .. T0+LAT.
- RUN: the counter decrements each edge. On the edge that ends cycle T0+LAT (counter 1 -> 0), write HI/LO and return to IDLE. New values and busy=0 are visible together from cycle T0+LAT+1.
- Results use the latched operands only. A/B changes during RUN have no effect.
- mult: {HI,LO} = signed(A) * signed(B), 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Example: -7/2 gives LO=-3 (0xFFFFFFFD), HI=-1 (0xFFFFFFFF).
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (latched B==0): full DIV_CYCLES busy period still runs; HI/LO keep their prior values.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: HI (or LO) = A at that edge; start is ignored for these ops; no busy period.
- Ops while busy: any start or mthi/mtlo while busy=1 is ignored. The controller must stall instead. The MDU neither queues nor aborts.
- start=1 with MDUOp 0 or 7: no effect.
- start=0 with MDUOp 1..4: no effect.
- Simultaneous completion and new request: a request at the completion edge is still ignored, because busy=1 during that cycle. The earliest relaunch is the following edge.
- HI/LO change only at:
  - completion edges;
  - mthi/mtlo edges;
  - reset.
- No combinational path from inputs to busy/HI/LO. All outputs are registers.

Test Plan:
- Reset, then idle 3 cycles -> HI=0, LO=0, busy=0 throughout.
- mult, A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA in the same cycle busy falls.
  - Repeat as multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> HI/LO updated the next cycle, busy stays 0.
  - Then divu with B=0 -> busy 10 cycles, HI/LO unchanged.
- During a mult busy period, drive start with div, then mtlo with A=0xDEADBEEF, and toggle A/B -> all ignored; final HI/LO equal the original mult result.
  - Request exactly at the completion edge -> also ignored.
- Assert reset in the 3rd busy cycle of a div -> the next cycle shows busy=0, HI=0, LO=0; no late write occurs afterwards.
